// File: rtl/uart_pkg.sv
// Shared UART constants for the serial receive path.
package uart_pkg;

  localparam int UART_DATA_W      = 8;
  localparam int UART_OVERSAMPLE  = 16;
  localparam int UART_RXBUF_DEPTH = 16;

endpackage : uart_pkg

// File: rtl/uart_sync_fifo.sv
// Generic single-clock first-word-fall-through FIFO with occupancy count.
// A pop on an empty FIFO is ignored. A push on a full FIFO is accepted only when a pop frees a slot in the same cycle.
module uart_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [AW:0]       count_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wp_q, wp_d;
  logic [AW-1:0]     rp_q, rp_d;
  logic [AW:0]       count_q, count_d;
  logic              do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign head_o  = mem_q[rp_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (do_push) wp_d = wp_q + AW'(1);
    if (do_pop)  rp_d = rp_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= push_data_i;
  end

  assign count_o = count_q;

endmodule : uart_sync_fifo

// File: rtl/uart_rx_buffer.sv
// Receive byte buffer: turns each rising edge of RX_STATUS into a FIFO push and flags dropped bytes.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter  int DEPTH = UART_RXBUF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   Clk_16_9600,
  input  logic                   reset,
  input  logic [UART_DATA_W-1:0] RX_DATA,
  input  logic                   RX_STATUS,
  input  logic                   rd_en,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic                   rd_valid,
  output logic                   full,
  output logic [AW:0]            count,
  output logic                   overrun,
  input  logic                   ovr_clr
);

  logic stat_q;
  logic overrun_q, overrun_d;
  logic push, pop, drop, empty;

  // stat_q resets high so a status already asserted at reset release is not taken as a new byte.
  assign push = RX_STATUS & ~stat_q;
  assign pop  = rd_en & rd_valid;
  assign drop = push & full & ~pop;

  assign rd_valid = ~empty;
  assign overrun  = overrun_q;

  // A drop in the same cycle as a clear keeps the flag set.
  always_comb begin
    overrun_d = overrun_q;
    if (drop)         overrun_d = 1'b1;
    else if (ovr_clr) overrun_d = 1'b0;
  end

  always_ff @(posedge Clk_16_9600 or negedge reset) begin
    if (!reset) begin
      stat_q    <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      stat_q    <= RX_STATUS;
      overrun_q <= overrun_d;
    end
  end

  uart_sync_fifo #(
    .DATA_W (UART_DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_fifo (
    .clk         (Clk_16_9600),
    .rst_n       (reset),
    .push_i      (push),
    .push_data_i (RX_DATA),
    .pop_i       (pop),
    .head_o      (rd_data),
    .empty_o     (empty),
    .full_o      (full),
    .count_o     (count)
  );

endmodule : uart_rx_buffer

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench for uart_rx_buffer: directed scenarios plus randomized traffic against a queue model.
module tb_uart_rx_buffer;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] RX_DATA;
  logic       RX_STATUS;
  logic       rd_en;
  logic       ovr_clr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic [4:0] count;
  logic       overrun;

  int total = 0;
  int bad   = 0;

  // Reference model: buffered bytes, sticky overrun, previous status level.
  byte unsigned mq[$];
  bit           m_ovr;
  bit           m_stat;

  always #5 clk = ~clk;

  uart_rx_buffer #(.DEPTH(DEPTH)) dut (
    .Clk_16_9600 (clk),
    .reset       (reset),
    .RX_DATA     (RX_DATA),
    .RX_STATUS   (RX_STATUS),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .full        (full),
    .count       (count),
    .overrun     (overrun),
    .ovr_clr     (ovr_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovr  = 1'b0;
    m_stat = 1'b1;
  endtask

  // Apply one clock edge's worth of the behavioural rules using the inputs as currently driven.
  task automatic model_edge();
    bit new_byte;
    bit dropped;
    if (!reset) begin
      model_reset();
      return;
    end
    new_byte = RX_STATUS && !m_stat;
    dropped  = 1'b0;
    if (rd_en && mq.size() != 0) void'(mq.pop_front());
    if (new_byte) begin
      if (mq.size() < DEPTH) mq.push_back(RX_DATA);
      else dropped = 1'b1;
    end
    if (dropped)      m_ovr = 1'b1;
    else if (ovr_clr) m_ovr = 1'b0;
    m_stat = RX_STATUS;
  endtask

  task automatic compare_outputs(input string tag);
    check({tag, ".count"},    32'(count),    32'(mq.size()));
    check({tag, ".rd_valid"}, 32'(rd_valid), 32'(mq.size() != 0));
    check({tag, ".full"},     32'(full),     32'(mq.size() == DEPTH));
    check({tag, ".overrun"},  32'(overrun),  32'(m_ovr));
    if (mq.size() != 0) check({tag, ".rd_data"}, 32'(rd_data), 32'(mq[0]));
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    compare_outputs(tag);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input string tag);
    RX_DATA   = b;
    RX_STATUS = 1'b1;
    repeat (hold) tick(tag);
    RX_STATUS = 1'b0;
    tick(tag);
  endtask

  task automatic drain(input string tag);
    rd_en = 1'b1;
    for (int i = 0; i < 2*DEPTH && mq.size() != 0; i++) tick(tag);
    rd_en = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    RX_DATA   = 8'h00;
    RX_STATUS = 1'b1;
    rd_en     = 1'b0;
    ovr_clr   = 1'b0;
    model_reset();

    // Status already high at reset release must not push.
    repeat (3) tick("in_reset");
    reset = 1'b1;
    repeat (200) tick("status_high_at_release");
    check("no_push_after_release", 32'(count), 32'd0);
    RX_STATUS = 1'b0;
    tick("idle");

    // Single byte held many cycles: exactly one push, then one pop.
    send_byte(8'h5A, 23, "single");
    check("single.count_one", 32'(count), 32'd1);
    check("single.data", 32'(rd_data), 32'h5A);
    rd_en = 1'b1;
    tick("single_pop");
    rd_en = 1'b0;
    check("single.empty_after_pop", 32'(rd_valid), 32'd0);

    // Fill to full, overflow, then read back in order.
    for (int i = 0; i < DEPTH; i++) send_byte(8'(i), 3, "fill");
    check("fill.full", 32'(full), 32'd1);
    check("fill.count16", 32'(count), 32'd16);
    send_byte(8'hAA, 4, "overflow");
    check("overflow.flag", 32'(overrun), 32'd1);
    check("overflow.count16", 32'(count), 32'd16);
    rd_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("readback.seq", 32'(rd_data), 32'(i));
      tick("readback");
    end
    rd_en = 1'b0;
    check("readback.empty", 32'(rd_valid), 32'd0);
    ovr_clr = 1'b1;
    tick("clear");
    ovr_clr = 1'b0;

    // Full FIFO: simultaneous push and pop is accepted without overrun.
    for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom), 2, "refill");
    RX_DATA   = 8'h77;
    RX_STATUS = 1'b1;
    rd_en     = 1'b1;
    tick("full_push_pop");
    rd_en = 1'b0;
    check("full_push_pop.count", 32'(count), 32'd16);
    check("full_push_pop.no_ovr", 32'(overrun), 32'd0);
    tick("full_push_pop");
    RX_STATUS = 1'b0;
    tick("full_push_pop");
    rd_en = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) tick("drain_to_last");
    check("last_is_77", 32'(rd_data), 32'h77);
    tick("drain_last");
    rd_en = 1'b0;

    // Set and clear of overrun in the same cycle: set wins.
    for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom), 2, "fill2");
    send_byte(8'h11, 2, "drop1");
    check("drop1.ovr", 32'(overrun), 32'd1);
    RX_DATA   = 8'h22;
    RX_STATUS = 1'b1;
    ovr_clr   = 1'b1;
    tick("set_and_clear");
    check("set_wins", 32'(overrun), 32'd1);
    tick("clear_alone");
    check("clear_alone", 32'(overrun), 32'd0);
    ovr_clr   = 1'b0;
    RX_STATUS = 1'b0;
    tick("after_clear");
    drain("drain2");

    // Asynchronous reset mid-cycle discards buffered bytes.
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 2, "pre_reset");
    check("pre_reset.count5", 32'(count), 32'd5);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("async_reset.count", 32'(count), 32'd0);
    check("async_reset.rd_valid", 32'(rd_valid), 32'd0);
    check("async_reset.full", 32'(full), 32'd0);
    check("async_reset.overrun", 32'(overrun), 32'd0);
    @(posedge clk);
    #1;
    repeat (2) tick("held_reset");
    reset = 1'b1;
    tick("post_reset");
    send_byte(8'h3C, 5, "post_reset_byte");
    check("post_reset.first", 32'(rd_data), 32'h3C);
    drain("drain3");

    // Randomized traffic with phases of slow and fast reading.
    begin
      int hold = 0;
      int gap  = 2;
      for (int c = 0; c < 4000; c++) begin
        int rd_pct = ((c / 500) % 2 == 0) ? 10 : 70;
        if (RX_STATUS) begin
          if (hold == 0) begin
            RX_STATUS = 1'b0;
            gap = $urandom_range(1, 6);
          end else hold--;
        end else begin
          if (gap == 0) begin
            RX_STATUS = 1'b1;
            RX_DATA   = 8'($urandom);
            hold = $urandom_range(0, 8);
          end else gap--;
        end
        rd_en   = ($urandom_range(0, 99) < rd_pct);
        ovr_clr = ($urandom_range(0, 99) < 3);
        tick("random");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_rx_buffer

// File: doc/uart_rx_buffer.md
# uart_rx_buffer

Receive-side byte buffer placed directly downstream of the UART receiver. It detects each completed-byte indication (rising edge of `RX_STATUS`) and pushes the accompanying `RX_DATA` byte into a first-word-fall-through FIFO. The CPU-side I/O logic drains the FIFO with a read strobe. Bytes that arrive while the FIFO is full are counted as an overrun.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; must be a power of two, at least 2.
- `AW`, $clog2(DEPTH): pointer width (derived, not overridden).

Ports:
- `Clk_16_9600`  in  1: clock, 16× the 9600-baud bit rate.
- `reset`  in  1: asynchronous, active-low.
- `RX_DATA`  in  8: received byte from the receiver; valid while `RX_STATUS`=1.
- `RX_STATUS`  in  1: receiver done flag (level); a 0→1 transition marks a new byte.
- `rd_en`  in  1: pop request from the consumer; ignored when `rd_valid`=0.
- `rd_data`  out  8: head-of-FIFO byte; valid when `rd_valid`=1.
- `rd_valid`  out  1: FIFO not empty.
- `full`  out  1: count equals `DEPTH`.
- `count`  out  AW+1: occupancy, 0..`DEPTH`.
- `overrun`  out  1: sticky flag; set when a byte is dropped.
- `ovr_clr`  in  1: synchronous clear for `overrun`.

## Operation
- Edge detect:
  - `stat_q` registers `RX_STATUS` every clock.
  - `push` = `RX_STATUS` & ~`stat_q`.
  - `RX_DATA` is sampled in the same cycle as `push`.
  - `stat_q` resets to 1, so a status already high at reset release never produces a push.
- FIFO:
  - Storage is `DEPTH`×8. Write pointer `wp` and read pointer `rp` are AW bits wide and wrap modulo `DEPTH`. `count` is kept separately.
  - `pop` = `rd_en` & `rd_valid`.
- Push/pop rules, per cycle:
  - push only, not full: write `mem[wp]`, `wp`+1, `count`+1.
  - push only, full: byte dropped, `overrun` set; pointers and `count` unchanged.
  - pop only: `rp`+1, `count`−1.
  - push and pop, not empty: both take effect, `count` unchanged. This holds when full too: the pop frees the slot, the push is accepted and no overrun is flagged.
  - push while empty with `rd_en`=1: the pop is ignored (`rd_valid`=0 that cycle); only the push takes effect.
- Overrun:
  - `overrun` is set by a dropped byte and cleared by `ovr_clr`.
  - If set and clear happen in the same cycle, set wins.
- Outputs:
  - `rd_data` = `mem[rp]`, read combinationally (FWFT).
  - `rd_valid` = (`count`≠0).
  - `full` = (`count`==`DEPTH`).
- Reset (async, `reset`=0):
  - `wp`=`rp`=0, `count`=0, `overrun`=0, `stat_q`=1.
  - Outputs: `rd_valid`=0, `full`=0, `count`=0, `overrun`=0. `rd_data` is don't-care (memory is not cleared).
  - Reset mid-operation discards all buffered bytes and any pending edge.

## Timing
- All state updates on posedge `Clk_16_9600`. The only asynchronous path is `reset`.
- Push latency: `RX_STATUS` first sampled high at edge N → byte written at edge N → `rd_valid`=1 and `rd_data` valid after edge N.
- Pop: `rd_en` high at edge M → next entry (or `rd_valid`=0) presented after edge M.
- At most one push per byte. `RX_STATUS` stays high for many cycles; only the first cycle counts.
- Minimum byte spacing from the receiver is far above 1 cycle, so the single-cycle edge detector needs no queueing.

## Structure
- Shared package `uart_pkg`:
  - `UART_DATA_W` = 8
  - `UART_OVERSAMPLE` = 16
  - `UART_RXBUF_DEPTH` = 16 (default for `DEPTH`)
- Sub-module `uart_sync_fifo`: generic single-clock FWFT FIFO with push/pop/count/full, DATA_W and DEPTH parameters.
- `uart_rx_buffer` holds the edge detector and the overrun logic, and instantiates the FIFO.

## Test plan
- Reset release with `RX_STATUS`=1 held, then left high for 200 cycles → no push; `count`=0, `rd_valid`=0.
- `RX_DATA`=0x5A with `RX_STATUS` 0→1 held 23 cycles → exactly one push; after that edge `rd_valid`=1, `rd_data`=0x5A, `count`=1. Then pulse `rd_en` for 1 cycle → `rd_valid`=0.
- Push 0x00..0x0F without reading → `full`=1, `count`=16. Push 0xAA → `overrun`=1, `count`=16. Read all 16 → sequence 0x00..0x0F (0xAA absent).
- FIFO full, push 0x77 and `rd_en` in the same cycle → `count` stays 16, `overrun` stays 0; 0x77 is read last.
- `overrun`=1, `ovr_clr` and a drop-causing push in the same cycle → `overrun` remains 1. `ovr_clr` alone next cycle → `overrun`=0.
- 5 bytes buffered, assert `reset` low mid-cycle → outputs go to their reset values immediately, without waiting for a clock edge; after release, a new byte 0x3C is read first.
